// File: rtl/latch_sched_pkg.sv
// Shared types and defaults for the latch bank write scheduler.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_W        = 8;
    localparam int DEF_NLAT     = 4;
    localparam int DEF_OPEN_CYC = 2;

    // Width of a down-counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/latch_bank_sched_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick
    import latch_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [GW-1:0]   win,
    output logic            any_valid
);

    int idx;

    // Walk the requesters in rotated order starting at ptr; the first hit wins.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any_valid && (i == idx) && req[i]) begin
                    any_valid = 1'b1;
                    win       = GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/latch_bank_sched.sv
// Write scheduler for a bank of level-sensitive latches. Round-robin grant, then
// SETUP / OPEN / HOLD so a latch enable is never high while its data changes.
// All outputs are registered. Optional readback check: LATCH_READBACK_CHK_EN.
module latch_bank_sched
    import latch_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int W        = DEF_W,
    parameter int NLAT     = DEF_NLAT,
    parameter int AW       = 2,
    parameter int OPEN_CYC = DEF_OPEN_CYC
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [W-1:0]            lat_d,
    output logic [NLAT-1:0]         lat_c,
    input  logic [NLAT*W-1:0]       lat_q,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    addr_err,
    output logic                    chk_err
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = cnt_width(OPEN_CYC);
    localparam logic [AW:0]   NLAT_V = NLAT[AW:0];
    localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   addr_r;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   win;
    logic            any_valid;
    logic [AW-1:0]   sel_addr;
    logic [W-1:0]    sel_data;
    logic            addr_ok;

    rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .win       (win),
        .any_valid (any_valid)
    );

    function automatic logic [NLAT-1:0] lat_onehot(input logic [AW-1:0] a);
        logic [NLAT-1:0] v;
        v = '0;
        for (int i = 0; i < NLAT; i++) v[i] = (i == int'(a));
        return v;
    endfunction

    function automatic logic [NREQ-1:0] req_onehot(input logic [GW-1:0] g);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) v[i] = (i == int'(g));
        return v;
    endfunction

    assign addr_ok = ({1'b0, addr_r} < NLAT_V);

    // Mux out the winning requester's address and data for capture at grant.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == int'(win)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*W +: W];
            end
        end
    end

    // Scheduler FSM; every output is a flop so lat_c cannot glitch.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_r   <= '0;
            ptr      <= '0;
            lat_d    <= '0;
            lat_c    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            addr_err <= 1'b0;
        end else begin
            ack      <= '0;
            addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_id <= win;
                        addr_r <= sel_addr;
                        lat_d  <= sel_data;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    cnt      <= CW'(OPEN_CYC - 1);
                    lat_c    <= addr_ok ? lat_onehot(addr_r) : '0;
                    addr_err <= !addr_ok;
                    state    <= OPEN;
                end
                OPEN: begin
                    if (cnt == '0) begin
                        lat_c <= '0;
                        ack   <= req_onehot(gnt_id);
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LATCH_READBACK_CHK_EN
    logic [W-1:0] rd_q;

    // Select the addressed latch output for comparison in HOLD.
    always_comb begin
        rd_q = '0;
        for (int i = 0; i < NLAT; i++) begin
            if (i == int'(addr_r)) rd_q = lat_q[i*W +: W];
        end
    end

    // Sticky readback mismatch flag, cleared only by reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            chk_err <= 1'b0;
        end else if ((state == HOLD) && addr_ok && (rd_q != lat_d)) begin
            chk_err <= 1'b1;
        end
    end
`else
    logic unused_latq;
    assign unused_latq = ^lat_q;
    assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_sched.sv
// Scoreboard bench for latch_bank_sched with a behavioural latch bank model.
module tb_latch_bank_sched;

    localparam int NREQ     = 4;
    localparam int W        = 8;
    localparam int NLAT     = 3;
    localparam int AW       = 2;
    localparam int OPEN_CYC = 2;
    localparam int GW       = $clog2(NREQ);

`ifdef LATCH_READBACK_CHK_EN
    localparam bit CHK_EXP = 1'b1;
`else
    localparam bit CHK_EXP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 clr;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*W-1:0]    req_data;
    logic [NREQ-1:0]      ack;
    logic [W-1:0]         lat_d;
    logic [NLAT-1:0]      lat_c;
    logic [NLAT*W-1:0]    lat_q;
    logic                 busy;
    logic [GW-1:0]        gnt_id;
    logic                 addr_err;
    logic                 chk_err;

    logic [AW-1:0] a [NREQ];
    logic [W-1:0]  d [NREQ];
    logic [W-1:0]  mem [NLAT];
    bit            bad_model = 1'b0;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        bit            err;
    } exp_t;

    exp_t sbq[$];
    int   ack_cyc[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   mptr   = 0;
    int   acks_seen = 0;

    latch_bank_sched #(
        .NREQ(NREQ), .W(W), .NLAT(NLAT), .AW(AW), .OPEN_CYC(OPEN_CYC)
    ) dut (
        .clk(clk), .clr(clr), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .lat_d(lat_d), .lat_c(lat_c), .lat_q(lat_q), .busy(busy),
        .gnt_id(gnt_id), .addr_err(addr_err), .chk_err(chk_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*W +: W]   = d[i];
        end
    end

    // Latch bank: transparent while c is high.
    always @(lat_c or lat_d) begin
        for (int i = 0; i < NLAT; i++) if (lat_c[i]) mem[i] = lat_d;
    end

    always_comb begin
        lat_q = '0;
        for (int i = 0; i < NLAT; i++) lat_q[i*W +: W] = bad_model ? ~mem[i] : mem[i];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [NLAT-1:0] exp_c(input exp_t e);
        logic [NLAT-1:0] v;
        v = '0;
        for (int i = 0; i < NLAT; i++) if (int'(e.addr) == i) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NREQ-1:0] exp_ack(input int id);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) if (id == i) v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: tracks each transaction window and scores it when ack appears.
    initial begin
        int t0, first_open, open_n, err_n, err_at;
        bit ld_bad, busy_q;
        logic [NLAT-1:0] seen_c;
        exp_t e;
        t0 = 0; first_open = 0; open_n = 0; err_n = 0; err_at = 0;
        ld_bad = 0; busy_q = 0; seen_c = '0;
        forever begin
            @(negedge clk);
            if (!clr) begin
                busy_q = 1'b0;
            end else begin
                if (busy && !busy_q) begin
                    t0 = cyc; first_open = 0; open_n = 0; err_n = 0; err_at = 0;
                    ld_bad = 0; seen_c = '0;
                end
                if (busy && sbq.size() > 0 && lat_d !== sbq[0].data) ld_bad = 1;
                if (lat_c != '0) begin
                    if (open_n == 0) first_open = cyc;
                    open_n++;
                    seen_c = seen_c | lat_c;
                end
                if (addr_err) begin
                    err_n++;
                    err_at = cyc - t0;
                end
                if (ack != '0) begin
                    acks_seen++;
                    ack_cyc.push_back(cyc);
                    if (sbq.size() == 0) begin
                        chk("ack_unexpected", ack, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_vec", ack, exp_ack(e.id));
                        chk("gnt_id", gnt_id, e.id);
                        chk("lat_d", lat_d, e.data);
                        chk("lat_d_stable", ld_bad, 0);
                        chk("lat_c_in_hold", lat_c, 0);
                        chk("busy_in_hold", busy, 1);
                        chk("open_cycles", open_n, e.err ? 0 : OPEN_CYC);
                        chk("lat_c_sel", seen_c, exp_c(e));
                        chk("addr_err_cnt", err_n, e.err ? 1 : 0);
                        chk("ack_time", cyc - t0, 1 + OPEN_CYC);
                        if (e.err) chk("addr_err_when", err_at, 1);
                        else begin
                            chk("open_start", first_open - t0, 1);
                            chk("latch_val", mem[e.addr], e.data);
                        end
                    end
                end
                busy_q = busy;
            end
        end
    end

    task automatic do_reset();
        clr = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        chk("rst_lat_c", lat_c, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_chk_err", chk_err, 0);
        sbq.delete();
        mptr = 0;
        clr = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Queue n expected grants for a held request mask, drive it, wait for the acks.
    task automatic run(input logic [NREQ-1:0] m, input int n, input bit early);
        int   tgt, p, t;
        bit   found;
        exp_t e;
        ack_cyc.delete();
        for (int k = 0; k < n; k++) begin
            p      = pick(m, mptr);
            e.id   = p;
            e.addr = a[p];
            e.data = d[p];
            e.err  = (int'(a[p]) >= NLAT);
            sbq.push_back(e);
            mptr = (p + 1) % NREQ;
        end
        tgt = acks_seen + n;
        @(negedge clk);
        req = m;
        if (early) begin
            found = 0;
            for (t = 0; t < 20 && !found; t++) begin
                @(negedge clk);
                if (lat_c != '0) found = 1;
            end
            chk("early_open_seen", found, 1);
            req  = '0;
            a[0] = '0;
            d[0] = 8'hFF;
        end
        for (t = 0; t < 100 * n && acks_seen < tgt; t++) @(negedge clk);
        chk("ack_count", acks_seen, tgt);
        req = '0;
        repeat (3) @(negedge clk);
        for (int k = 1; k < ack_cyc.size(); k++)
            chk("ack_gap", ack_cyc[k] - ack_cyc[k-1], OPEN_CYC + 3);
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        clr = 1'b0;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        do_reset();

        // single write: requester 0 to latch 2
        a[0] = 2'd2; d[0] = 8'hA5;
        run(4'b0001, 1, 1'b0);
        chk("chk_err_good", chk_err, 0);

        // round robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(i % NLAT);
            d[i] = W'(8'h10 + i);
        end
        run(4'b1111, 5, 1'b0);

        // out-of-range address
        a[1] = 2'd3; d[1] = 8'h5A;
        run(4'b0010, 1, 1'b0);

        // request drops and data changes after grant
        a[0] = 2'd1; d[0] = 8'h3C;
        run(4'b0001, 1, 1'b1);

        // readback against a faulty latch model, then a clean write
        bad_model = 1'b1;
        a[2] = 2'd0; d[2] = 8'h77;
        run(4'b0100, 1, 1'b0);
        chk("chk_err_set", chk_err, CHK_EXP);
        bad_model = 1'b0;
        a[3] = 2'd1; d[3] = 8'h99;
        run(4'b1000, 1, 1'b0);
        chk("chk_err_sticky", chk_err, CHK_EXP);

        // reset during the first OPEN cycle
        a[0] = 2'd1; d[0] = 8'h42;
        @(negedge clk);
        req = 4'b0001;
        found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (lat_c != '0) found = 1;
        end
        chk("mw_open_seen", found, 1);
        clr = 1'b0;
        #1;
        chk("mw_lat_c_async", lat_c, 0);
        chk("mw_busy_async", busy, 0);
        req = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        sbq.delete();
        mptr = 0;
        repeat (4) @(negedge clk);
        chk("mw_idle_busy", busy, 0);
        chk("mw_gnt_id", gnt_id, 0);
        chk("mw_chk_err", chk_err, 0);

        // pointer must be back at 0: 1010 grants requester 1 first
        a[1] = 2'd2; d[1] = 8'hC3;
        a[3] = 2'd1; d[3] = 8'h3E;
        run(4'b1010, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
